// File: rtl/seq_restoring_divider_if.sv
// Operand/result bundle for the sequential restoring divider.
// div_zero exists only when DIV_ZERO_DETECT_EN is defined.
interface seq_restoring_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
`ifdef DIV_ZERO_DETECT_EN
   logic             div_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_zero
   );
`else
   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done
   );
`endif
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, fixed WIDTH-cycle latency.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits to DONE and raises div_zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per cycle, WIDTH cycles total
// DONE  | results valid, done pulse; start here chains the next operation
module seq_restoring_divider #(
   parameter int WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   seq_restoring_divider_if.slave bus
);
   localparam int              CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic [WIDTH:0]   cand;
   logic             q_bit;
   logic [WIDTH-1:0] rem_step, dvd_step;
   logic             accept, last_step, zero_skip;

   assign accept    = bus.start && (state != RUN);
   assign last_step = (state == RUN) && (cnt == LAST);

`ifdef DIV_ZERO_DETECT_EN
   logic div_zero_q;
   assign zero_skip    = accept && (bus.divisor == '0);
   assign bus.div_zero = div_zero_q;
`else
   assign zero_skip = 1'b0;
`endif

   // cand never exceeds 2*divisor-1, so the low WIDTH bits of the difference are exact
   assign cand     = {rem_q, dvd_q[WIDTH-1]};
   assign q_bit    = (cand >= {1'b0, dvs_q});
   assign rem_step = q_bit ? (cand[WIDTH-1:0] - dvs_q) : cand[WIDTH-1:0];
   assign dvd_step = {dvd_q[WIDTH-2:0], q_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = zero_skip ? DONE : RUN;
         RUN:  if (cnt == LAST) state_nxt = DONE;
         DONE: begin
            if (accept) state_nxt = zero_skip ? DONE : RUN;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
         div_zero_q  <= 1'b0;
`endif
      end else if (accept) begin
         dvd_q <= bus.dividend;
         dvs_q <= bus.divisor;
         rem_q <= '0;
         cnt   <= '0;
`ifdef DIV_ZERO_DETECT_EN
         if (zero_skip) begin
            quotient_q  <= '1;
            remainder_q <= bus.dividend;
            div_zero_q  <= 1'b1;
         end
`endif
      end else if (state == RUN) begin
         rem_q <= rem_step;
         dvd_q <= dvd_step;
         cnt   <= cnt + CW'(1);
         if (last_step) begin
            quotient_q  <= dvd_step;
            remainder_q <= rem_step;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= 1'b0;
`endif
         end
      end
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed corner cases plus random
// operands compared against plain integer division.
module tb_seq_restoring_divider;
   localparam int WIDTH = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int          n_chk  = 0;
   int          n_err  = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output bit dz);
      dz  = 1'b0;
      lat = WIDTH;
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
`ifdef DIV_ZERO_DETECT_EN
         lat = 1;
         dz  = 1'b1;
`endif
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
   endtask

   // Call with start already raised; consumes the accept edge and stops in the done cycle.
   task automatic await_result(input logic [31:0] a, input logic [31:0] b,
                               input string tag, input bit scramble);
      logic [31:0] q, r;
      int          lat, j;
      bit          dz;
      model(a, b, q, r, lat, dz);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, " busy_after_accept"}, 64'(bus.busy), 64'(lat != 1));
      j = 0;
      while (!bus.done && j < 100) begin
         if (j == 5) chk({tag, " quotient_held"}, 64'(bus.quotient), 64'(last_q));
         if (scramble) begin
            bus.start    = 1'($urandom);
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
         end
         @(posedge clk); #1;
         j++;
      end
      bus.start = 1'b0;
      chk({tag, " latency"}, 64'(j), 64'(lat));
      chk({tag, " quotient"}, 64'(bus.quotient), 64'(q));
      chk({tag, " remainder"}, 64'(bus.remainder), 64'(r));
      chk({tag, " busy_in_done"}, 64'(bus.busy), 64'(0));
`ifdef DIV_ZERO_DETECT_EN
      chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(dz));
`endif
      last_q = q;
      last_r = r;
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 64'(bus.done), 64'(0));
      chk({tag, " idle_busy"}, 64'(bus.busy), 64'(0));
      chk({tag, " result_hold"}, 64'({bus.quotient, bus.remainder}), {last_q, last_r});
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b, input string tag);
      launch(a, b);
      await_result(a, b, tag, 1'b0);
      idle_check(tag);
   endtask

   initial begin
      bit          seen;
      logic [31:0] a, b;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #1;
      chk("reset outputs", 64'({bus.quotient, bus.remainder}), 64'(0));
      chk("reset flags", 64'({bus.busy, bus.done}), 64'(0));
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("start ignored in reset", 64'({bus.busy, bus.done}), 64'(0));
      bus.start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      op(32'd100, 32'd7, "d100_7");
      op(32'hA0A0_FFFF, 32'h10, "dA0A0FFFF_10");

      launch(32'd5, 32'd9);
      await_result(32'd5, 32'd9, "b2b_first", 1'b0);
      launch(32'hFFFF_FFFF, 32'd1);
      await_result(32'hFFFF_FFFF, 32'd1, "b2b_second", 1'b0);
      idle_check("b2b_second");

      op(32'h1234, 32'd0, "div_by_zero");
      op(32'd77, 32'd77, "equal_ops");
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_ops");
      op(32'd0, 32'd3, "zero_dividend");

      launch(32'hDEAD_BEEF, 32'h1F3);
      await_result(32'hDEAD_BEEF, 32'h1F3, "scramble", 1'b1);
      idle_check("scramble");

      // Abort mid-RUN with a one-cycle reset pulse
      launch(32'd1000, 32'd3);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("abort busy_at_run10", 64'(bus.busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("abort outputs", 64'({bus.quotient, bus.remainder}), 64'(0));
      chk("abort flags", 64'({bus.busy, bus.done}), 64'(0));
`ifdef DIV_ZERO_DETECT_EN
      chk("abort div_zero", 64'(bus.div_zero), 64'(0));
`endif
      last_q = '0;
      last_r = '0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= bus.done | bus.busy;
      end
      chk("abort no_done", 64'(seen), 64'(0));

      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case (i % 4)
            0: b = $urandom;
            1: b = $urandom_range(1, 255);
            2: b = a + $urandom_range(1, 1000);
            default: b = (i == 7) ? 32'd0 : 32'd1 << $urandom_range(0, 31);
         endcase
         launch(a, b);
         await_result(a, b, $sformatf("rand%0d", i), 1'(i % 3 == 0));
         if (i % 2 == 1) idle_check($sformatf("rand%0d", i));
         else begin @(posedge clk); #1; end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand, quotient and remainder width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1: request to begin a division; sampled on the rising edge of clk.
REQ-005 The block SHALL have port dividend, input, WIDTH: unsigned numerator; captured only when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH: unsigned denominator; captured only when start is accepted.
REQ-007 The block SHALL have port quotient, output, WIDTH: unsigned floor(dividend/divisor) result.
REQ-008 The block SHALL have port remainder, output, WIDTH: unsigned dividend mod divisor result.
REQ-009 The block SHALL have port busy, output, 1: high while an iteration sequence is in progress.
REQ-010 The block SHALL have port done, output, 1: single-cycle result-valid pulse.
REQ-011 The block SHALL have port div_zero, output, 1: divide-by-zero flag; present only under DIV_ZERO_DETECT_EN.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DONE, plus an iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL be accepted: capture both operands, clear the partial remainder and the counter, and enter RUN.
REQ-014 In RUN, start SHALL be ignored, and operand input changes SHALL NOT affect the result in progress.
REQ-015 Each RUN cycle SHALL perform one restoring step: shift {partial remainder, dividend} left by 1 bit, trial-subtract the divisor using a (WIDTH+1)-bit difference, keep the difference and shift in a quotient bit of 1 if it is non-negative, otherwise restore and shift in 0.
REQ-016 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; done SHALL be high for exactly the one cycle spent in DONE.
REQ-017 Latency SHALL be fixed: done is high in the cycle following edge N+WIDTH, where edge N is the start-accept edge.
REQ-018 From DONE with start=0, the FSM SHALL return to IDLE; with start=1, it SHALL re-enter RUN, allowing back-to-back operations.
REQ-019 busy SHALL equal (state==RUN).
REQ-020 quotient and remainder SHALL update only on entry to DONE and SHALL hold stable until the next entry to DONE or reset; intermediate values SHALL NOT be visible on them.
REQ-021 With divisor 0 and without the macro, the block SHALL produce the natural algorithm result: quotient all-ones and remainder equal to dividend, with normal latency.
REQ-022 A dividend smaller than the divisor SHALL yield quotient 0 and remainder equal to dividend.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, counter 0, quotient 0, remainder 0, busy 0, done 0 and div_zero 0, without waiting for a clock edge.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for it.
REQ-025 start SHALL be ignored on any edge where rst_n is low.

Configuration
REQ-026 When macro DIV_ZERO_DETECT_EN is defined, an accepted start with divisor 0 SHALL skip RUN and go directly to DONE on the next edge, with quotient all-ones, remainder equal to dividend, div_zero=1 and busy never asserted.
REQ-027 When DIV_ZERO_DETECT_EN is defined, div_zero SHALL hold its value with quotient and remainder, and SHALL be cleared on the next entry to DONE that has a non-zero divisor.
REQ-028 When DIV_ZERO_DETECT_EN is undefined, port div_zero SHALL be absent and REQ-021 SHALL apply.

Verification
REQ-029 A bench SHALL apply WIDTH=32, dividend=100, divisor=7 -> quotient=14, remainder=2, with done exactly 32 cycles after the accept edge.
REQ-030 A bench SHALL apply dividend=0xA0A0FFFF, divisor=0x10 -> quotient=0x0A0A0FFF, remainder=0xF.
REQ-031 A bench SHALL apply dividend=5, divisor=9, then start again in the DONE cycle with dividend=0xFFFFFFFF, divisor=1 -> first result quotient=0, remainder=5; second result quotient=0xFFFFFFFF, remainder=0, with no idle gap between operations.
REQ-032 A bench SHALL apply dividend=0x1234, divisor=0 -> with the macro: done after 1 cycle, div_zero=1, quotient=0xFFFFFFFF, remainder=0x1234; without the macro: the same values after 32 cycles.
REQ-033 A bench SHALL assert rst_n=0 for one cycle at RUN cycle 10 -> all outputs 0 immediately, state IDLE, and no done pulse for that operation.
REQ-034 A bench SHALL toggle start and the operands during RUN -> the result SHALL match the originally captured operands.
